// File: rtl/dcache_mshr_file.sv
// Miss-status holding register file for the data cache: tracks outstanding line misses,
// issues them to memory in order and frees them on refill. Load merging: DCACHE_MSHR_MERGE_EN.
module dcache_mshr_file #(
  parameter int NUM_MSHR    = 4,
  parameter int ADDR_WIDTH  = 56,
  parameter int LINE_OFFSET = 4,
  parameter int ID_WIDTH    = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        alloc_valid_i,
  output logic                        alloc_ready_o,
  input  logic [ADDR_WIDTH-1:0]       alloc_addr_i,
  input  logic                        alloc_we_i,
  input  logic [ID_WIDTH-1:0]         alloc_id_i,
  output logic [$clog2(NUM_MSHR)-1:0] alloc_idx_o,
  output logic                        alloc_merge_o,
  input  logic [ADDR_WIDTH-1:0]       lookup_addr_i,
  output logic                        lookup_hit_o,
  output logic                        mem_req_valid_o,
  input  logic                        mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]       mem_req_addr_o,
  output logic [ID_WIDTH-1:0]         mem_req_id_o,
  output logic [$clog2(NUM_MSHR)-1:0] mem_req_idx_o,
  input  logic                        refill_valid_i,
  input  logic [$clog2(NUM_MSHR)-1:0] refill_idx_i,
  output logic [1:0]                  refill_merge_cnt_o,
  output logic                        full_o,
  output logic [$clog2(NUM_MSHR):0]   count_o,
  output logic                        err_o
);

  localparam int IDX_W  = $clog2(NUM_MSHR);
  localparam int LINE_W = ADDR_WIDTH - LINE_OFFSET;

  localparam logic [1:0] ST_FREE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

`ifdef DCACHE_MSHR_MERGE_EN
  localparam bit MERGE_EN = 1'b1;
`else
  localparam bit MERGE_EN = 1'b0;
`endif

  logic [1:0]          state_q [NUM_MSHR];
  logic [1:0]          cnt_q   [NUM_MSHR];
  logic [LINE_W-1:0]   line_q  [NUM_MSHR];
  logic [ID_WIDTH-1:0] id_q    [NUM_MSHR];
  logic [NUM_MSHR-1:0] we_q;
  logic                err_q;
  logic                hold_q;
  logic [IDX_W-1:0]    hold_idx_q;

  logic [LINE_W-1:0]   alloc_line, lookup_line;
  logic [NUM_MSHR-1:0] free_vec, wait_vec, pend_vec, match_vec, lookup_vec, merge_vec;
  logic [IDX_W-1:0]    free_idx, wait_idx, merge_idx, sel_idx;
  logic [IDX_W:0]      count_n;
  logic                merge_hit, alloc_fire, alloc_new, issue_fire, refill_ok;

  assign alloc_line  = alloc_addr_i[ADDR_WIDTH-1:LINE_OFFSET];
  assign lookup_line = lookup_addr_i[ADDR_WIDTH-1:LINE_OFFSET];

  // Byte-offset bits never take part in line matching.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{alloc_addr_i[LINE_OFFSET-1:0], lookup_addr_i[LINE_OFFSET-1:0]};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    free_vec   = '0;
    wait_vec   = '0;
    pend_vec   = '0;
    match_vec  = '0;
    lookup_vec = '0;
    merge_vec  = '0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      free_vec[i]   = (state_q[i] == ST_FREE);
      wait_vec[i]   = (state_q[i] == ST_WAIT);
      pend_vec[i]   = (state_q[i] == ST_PEND);
      match_vec[i]  = !free_vec[i] && (line_q[i] == alloc_line);
      lookup_vec[i] = !free_vec[i] && (line_q[i] == lookup_line);
      // An entry being freed this cycle cannot absorb a merge: the merge would be lost.
      merge_vec[i]  = MERGE_EN && match_vec[i] && !alloc_we_i && !we_q[i] &&
                      (cnt_q[i] != 2'd3) &&
                      !(refill_valid_i && (refill_idx_i == IDX_W'(i)));
    end
  end

  // Descending scan so the lowest index wins.
  always_comb begin
    free_idx  = '0;
    wait_idx  = '0;
    merge_idx = '0;
    count_n   = '0;
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      if (free_vec[i])  free_idx  = IDX_W'(i);
      if (wait_vec[i])  wait_idx  = IDX_W'(i);
      if (merge_vec[i]) merge_idx = IDX_W'(i);
    end
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (!free_vec[i]) count_n = count_n + (IDX_W+1)'(1);
    end
  end

  assign merge_hit     = |merge_vec;
  assign alloc_ready_o = merge_hit || ((|free_vec) && !(|match_vec));
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;
  assign alloc_new     = alloc_fire && !merge_hit;
  assign alloc_idx_o   = merge_hit ? merge_idx : free_idx;
  assign alloc_merge_o = alloc_valid_i && merge_hit;
  assign lookup_hit_o  = |lookup_vec;

  // A request already on the bus stays selected until it is accepted.
  assign sel_idx         = hold_q ? hold_idx_q : wait_idx;
  assign mem_req_valid_o = |wait_vec;
  assign mem_req_idx_o   = sel_idx;
  assign mem_req_addr_o  = {line_q[sel_idx], {LINE_OFFSET{1'b0}}};
  assign mem_req_id_o    = id_q[sel_idx];
  assign issue_fire      = mem_req_valid_o && mem_req_ready_i;

  assign refill_ok          = refill_valid_i && pend_vec[refill_idx_i];
  assign refill_merge_cnt_o = (MERGE_EN && refill_valid_i) ? cnt_q[refill_idx_i] : 2'd0;

  assign count_o = count_n;
  assign full_o  = (count_n == (IDX_W+1)'(NUM_MSHR));
  assign err_o   = err_q;

  // Alloc, issue and refill act on entries in different states, so they never collide.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        state_q[i] <= ST_FREE;
        cnt_q[i]   <= 2'd0;
      end
      err_q      <= 1'b0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        if (alloc_new && (free_idx == IDX_W'(i))) begin
          state_q[i] <= ST_WAIT;
          cnt_q[i]   <= 2'd0;
        end
        if (alloc_fire && merge_hit && (merge_idx == IDX_W'(i))) cnt_q[i] <= cnt_q[i] + 2'd1;
        if (issue_fire && (sel_idx == IDX_W'(i))) state_q[i] <= ST_PEND;
        if (refill_ok && (refill_idx_i == IDX_W'(i))) state_q[i] <= ST_FREE;
      end
      if (refill_valid_i && !pend_vec[refill_idx_i]) err_q <= 1'b1;
      hold_q     <= mem_req_valid_o && !mem_req_ready_i;
      hold_idx_q <= sel_idx;
    end
  end

  // NOTE: payload storage is not reset; it is only observed while its entry is non-FREE.
  always_ff @(posedge clk_i) begin
    if (alloc_new) begin
      line_q[free_idx] <= alloc_line;
      id_q[free_idx]   <= alloc_id_i;
      we_q[free_idx]   <= alloc_we_i;
    end
  end

endmodule

// File: tb/tb_dcache_mshr_file.sv
// Self-checking bench for dcache_mshr_file; issue order and payload are checked
// against a scoreboard filled at allocation time.
module tb_dcache_mshr_file;
  localparam int NUM_MSHR = 4;
  localparam int AW       = 56;
  localparam int IW       = 2;
  localparam int XW       = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          alloc_valid_i = 1'b0;
  logic          alloc_ready_o;
  logic [AW-1:0] alloc_addr_i = '0;
  logic          alloc_we_i = 1'b0;
  logic [IW-1:0] alloc_id_i = '0;
  logic [XW-1:0] alloc_idx_o;
  logic          alloc_merge_o;
  logic [AW-1:0] lookup_addr_i = '0;
  logic          lookup_hit_o;
  logic          mem_req_valid_o;
  logic          mem_req_ready_i = 1'b0;
  logic [AW-1:0] mem_req_addr_o;
  logic [IW-1:0] mem_req_id_o;
  logic [XW-1:0] mem_req_idx_o;
  logic          refill_valid_i = 1'b0;
  logic [XW-1:0] refill_idx_i = '0;
  logic [1:0]    refill_merge_cnt_o;
  logic          full_o;
  logic [XW:0]   count_o;
  logic          err_o;

  typedef struct {
    logic [XW-1:0] idx;
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
  } req_t;

  req_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  dcache_mshr_file #(.NUM_MSHR(NUM_MSHR), .ADDR_WIDTH(AW), .LINE_OFFSET(4), .ID_WIDTH(IW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_addr_i(alloc_addr_i),
    .alloc_we_i(alloc_we_i), .alloc_id_i(alloc_id_i), .alloc_idx_o(alloc_idx_o),
    .alloc_merge_o(alloc_merge_o), .lookup_addr_i(lookup_addr_i), .lookup_hit_o(lookup_hit_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_id_o(mem_req_id_o), .mem_req_idx_o(mem_req_idx_o),
    .refill_valid_i(refill_valid_i), .refill_idx_i(refill_idx_i),
    .refill_merge_cnt_o(refill_merge_cnt_o), .full_o(full_o), .count_o(count_o), .err_o(err_o)
  );

  // Allocation expected to create a new entry at exp_idx; queued for the issue check.
  task automatic alloc(input logic [AW-1:0] addr, input logic we, input logic [IW-1:0] id,
                       input logic [XW-1:0] exp_idx);
    req_t r;
    @(negedge clk_i);
    alloc_valid_i = 1'b1; alloc_addr_i = addr; alloc_we_i = we; alloc_id_i = id;
    #1;
    vectors++;
    if (alloc_ready_o !== 1'b1 || alloc_idx_o !== exp_idx || alloc_merge_o !== 1'b0) begin
      miscompares++;
      $display("FAIL alloc %h: ready=%b idx=%0d merge=%b, want ready=1 idx=%0d merge=0",
               addr, alloc_ready_o, alloc_idx_o, alloc_merge_o, exp_idx);
    end
    r.idx = exp_idx; r.addr = {addr[AW-1:4], 4'h0}; r.id = id;
    sb.push_back(r);
    @(posedge clk_i); #1;
    alloc_valid_i = 1'b0;
  endtask

  // Accept n memory requests, each compared against the head of the scoreboard.
  task automatic drain(input int n);
    req_t e;
    int t;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_i);
      mem_req_ready_i = 1'b1;
      #1;
      t = 0;
      while (!mem_req_valid_o && t < 20) begin
        @(negedge clk_i); #1; t++;
      end
      vectors++;
      if (!mem_req_valid_o || sb.size() == 0) begin
        miscompares++;
        $display("FAIL issue_timeout: valid=%b queued=%0d, want a request", mem_req_valid_o, sb.size());
      end else begin
        e = sb.pop_front();
        if (mem_req_idx_o !== e.idx || mem_req_addr_o !== e.addr || mem_req_id_o !== e.id) begin
          miscompares++;
          $display("FAIL issue: idx=%0d addr=%h id=%0d, want idx=%0d addr=%h id=%0d",
                   mem_req_idx_o, mem_req_addr_o, mem_req_id_o, e.idx, e.addr, e.id);
        end
      end
      @(posedge clk_i); #1;
      mem_req_ready_i = 1'b0;
    end
  endtask

  task automatic refill(input logic [XW-1:0] idx, input logic [1:0] exp_cnt);
    @(negedge clk_i);
    refill_valid_i = 1'b1; refill_idx_i = idx;
    #1;
    vectors++;
    if (refill_merge_cnt_o !== exp_cnt) begin
      miscompares++;
      $display("FAIL refill_merge_cnt idx %0d: got %0d want %0d", idx, refill_merge_cnt_o, exp_cnt);
    end
    @(posedge clk_i); #1;
    refill_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    alloc_valid_i = 1'b0; mem_req_ready_i = 1'b0; refill_valid_i = 1'b0;
    alloc_addr_i = 56'h9000; lookup_addr_i = 56'h9000;
    rst_ni = 1'b0;
    #1;
    for (int pass = 0; pass < 2; pass++) begin
      vectors++;
      if ({alloc_ready_o, mem_req_valid_o, lookup_hit_o, full_o, alloc_merge_o, err_o} !== 6'b100000 ||
          count_o !== 3'd0) begin
        miscompares++;
        $display("FAIL reset_outputs pass %0d: rdy=%b mreq=%b hit=%b full=%b merge=%b err=%b cnt=%0d, want 1 0 0 0 0 0 0",
                 pass, alloc_ready_o, mem_req_valid_o, lookup_hit_o, full_o, alloc_merge_o, err_o, count_o);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i); #1;
    end
    sb.delete();
  endtask

  task automatic test_single();
    alloc(56'h1000, 1'b0, 2'd1, 2'd0);
    @(negedge clk_i);
    lookup_addr_i = 56'h100c;
    #1;
    vectors++;
    if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 56'h1000 || count_o !== 3'd1 || lookup_hit_o !== 1'b1) begin
      miscompares++;
      $display("FAIL single: mreq=%b addr=%h cnt=%0d hit=%b, want 1 1000 1 1",
               mem_req_valid_o, mem_req_addr_o, count_o, lookup_hit_o);
    end
    lookup_addr_i = 56'h1010;
    #1;
    vectors++;
    if (lookup_hit_o !== 1'b0) begin
      miscompares++;
      $display("FAIL lookup_other_line: got %b want 0", lookup_hit_o);
    end
    drain(1);
    refill(2'd0, 2'd0);
    @(negedge clk_i); #1;
    vectors++;
    if (count_o !== 3'd0 || mem_req_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_freed: cnt=%0d mreq=%b, want 0 0", count_o, mem_req_valid_o);
    end
  endtask

  task automatic test_fill_order();
    for (int k = 0; k < NUM_MSHR; k++)
      alloc(56'h3000 + 56'(k * 16), 1'(k % 2), IW'(k), XW'(k));
    @(negedge clk_i);
    alloc_valid_i = 1'b1; alloc_addr_i = 56'h4000; alloc_we_i = 1'b0;
    #1;
    vectors++;
    if (full_o !== 1'b1 || count_o !== 3'd4 || alloc_ready_o !== 1'b0 || mem_req_idx_o !== 2'd0) begin
      miscompares++;
      $display("FAIL full: full=%b cnt=%0d rdy=%b idx=%0d, want 1 4 0 0", full_o, count_o, alloc_ready_o, mem_req_idx_o);
    end
    @(posedge clk_i); #1;
    alloc_valid_i = 1'b0;
    drain(NUM_MSHR);
  endtask

  // Entries 2,3 pending, 0,1 free: refill 2 and allocate in the same cycle.
  task automatic test_concurrent();
    refill(2'd0, 2'd0);
    refill(2'd1, 2'd0);
    @(negedge clk_i);
    refill_valid_i = 1'b1; refill_idx_i = 2'd2;
    alloc_valid_i = 1'b1; alloc_addr_i = 56'h5000; alloc_we_i = 1'b0; alloc_id_i = 2'd3;
    #1;
    vectors++;
    if (alloc_ready_o !== 1'b1 || alloc_idx_o !== 2'd0) begin
      miscompares++;
      $display("FAIL concurrent_alloc: rdy=%b idx=%0d, want 1 0", alloc_ready_o, alloc_idx_o);
    end
    sb.push_back('{2'd0, 56'h5000, 2'd3});
    @(posedge clk_i); #1;
    refill_valid_i = 1'b0; alloc_valid_i = 1'b0;
    @(negedge clk_i); #1;
    vectors++;
    if (count_o !== 3'd2) begin
      miscompares++;
      $display("FAIL concurrent_count: got %0d want 2", count_o);
    end
    alloc(56'h5010, 1'b0, 2'd0, 2'd1);
    alloc(56'h5020, 1'b1, 2'd2, 2'd2);
    drain(3);
    for (int k = 0; k < NUM_MSHR; k++) refill(XW'(k), 2'd0);
  endtask

  // A lower entry becoming ready must not steal the bus from the presented one.
  task automatic test_issue_hold();
    alloc(56'h6000, 1'b0, 2'd0, 2'd0);
    alloc(56'h6010, 1'b0, 2'd1, 2'd1);
    drain(1);
    refill(2'd0, 2'd0);
    alloc(56'h6020, 1'b0, 2'd2, 2'd0);
    @(negedge clk_i); #1;
    vectors++;
    if (mem_req_idx_o !== 2'd1 || mem_req_addr_o !== 56'h6010) begin
      miscompares++;
      $display("FAIL issue_hold: idx=%0d addr=%h, want 1 6010", mem_req_idx_o, mem_req_addr_o);
    end
    drain(2);
    refill(2'd1, 2'd0);
    refill(2'd0, 2'd0);
  endtask

`ifndef DCACHE_MSHR_MERGE_EN
  task automatic test_hold_off();
    alloc(56'h2000, 1'b0, 2'd1, 2'd0);
    @(negedge clk_i);
    alloc_valid_i = 1'b1; alloc_addr_i = 56'h2008; alloc_we_i = 1'b0; alloc_id_i = 2'd2;
    #1;
    vectors++;
    if (alloc_ready_o !== 1'b0 || alloc_merge_o !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_off_wait: rdy=%b merge=%b, want 0 0", alloc_ready_o, alloc_merge_o);
    end
    drain(1);
    @(negedge clk_i);
    refill_valid_i = 1'b1; refill_idx_i = 2'd0;
    #1;
    vectors++;
    if (alloc_ready_o !== 1'b0 || refill_merge_cnt_o !== 2'd0) begin
      miscompares++;
      $display("FAIL hold_off_refill: rdy=%b mcnt=%0d, want 0 0", alloc_ready_o, refill_merge_cnt_o);
    end
    @(posedge clk_i); #1;
    refill_valid_i = 1'b0;
    @(negedge clk_i); #1;
    vectors++;
    if (alloc_ready_o !== 1'b1 || alloc_idx_o !== 2'd0) begin
      miscompares++;
      $display("FAIL hold_off_release: rdy=%b idx=%0d, want 1 0", alloc_ready_o, alloc_idx_o);
    end
    sb.push_back('{2'd0, 56'h2000, 2'd2});
    @(posedge clk_i); #1;
    alloc_valid_i = 1'b0;
    drain(1);
    refill(2'd0, 2'd0);
  endtask
`else
  // Four loads to one 16-byte line: three merge, the fourth stalls on a saturated count.
  task automatic test_merge();
    logic [AW-1:0] addrs [4];
    addrs[0] = 56'h2004; addrs[1] = 56'h2008; addrs[2] = 56'h200c; addrs[3] = 56'h2001;
    alloc(56'h2000, 1'b0, 2'd1, 2'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      alloc_valid_i = 1'b1; alloc_addr_i = addrs[k]; alloc_we_i = 1'b0;
      #1;
      vectors++;
      if (k < 3 && (alloc_ready_o !== 1'b1 || alloc_merge_o !== 1'b1 || alloc_idx_o !== 2'd0)) begin
        miscompares++;
        $display("FAIL merge %0d: rdy=%b merge=%b idx=%0d, want 1 1 0", k, alloc_ready_o, alloc_merge_o, alloc_idx_o);
      end
      if (k == 3 && (alloc_ready_o !== 1'b0 || count_o !== 3'd1)) begin
        miscompares++;
        $display("FAIL merge_saturated: rdy=%b cnt=%0d, want 0 1", alloc_ready_o, count_o);
      end
      @(posedge clk_i); #1;
      alloc_valid_i = 1'b0;
    end
    drain(1);
    refill(2'd0, 2'd3);
  endtask
`endif

  task automatic test_err_reset();
    @(negedge clk_i);
    refill_valid_i = 1'b1; refill_idx_i = 2'd1;
    @(posedge clk_i); #1;
    refill_valid_i = 1'b0;
    @(negedge clk_i); #1;
    vectors++;
    if (err_o !== 1'b1 || count_o !== 3'd0 || mem_req_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL err_free_refill: err=%b cnt=%0d mreq=%b, want 1 0 0", err_o, count_o, mem_req_valid_o);
    end
    alloc(56'h7000, 1'b0, 2'd0, 2'd0);
    alloc(56'h7010, 1'b1, 2'd1, 2'd1);
    drain(1);
    test_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fill_order();
    test_concurrent();
    test_issue_hold();
`ifndef DCACHE_MSHR_MERGE_EN
    test_hold_off();
`else
    test_merge();
`endif
    test_err_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
